// File: rtl/ascon_pkg.sv
// Shared Ascon permutation definitions: rotation amounts, round constant,
// state type and controller states.
package ascon_pkg;

  localparam int NROUNDS_MAX = 12;
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  typedef logic [4:0][63:0] ascon_state_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } perm_fsm_e;

  function automatic logic [63:0] rc(input logic [3:0] r);
    return {56'b0, 4'hF - r, r};
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, bit-sliced S-box, linear layer.
// With i_enable low the state passes through untouched.
module ascon_round
  import ascon_pkg::*;
(
  input  ascon_state_t i_state,
  input  logic [3:0]   i_round,
  input  logic         i_enable,
  output ascon_state_t o_state
);

  ascon_state_t w_c;
  ascon_state_t w_s;
  ascon_state_t w_l;
  logic [63:0]  w_b0, w_b1, w_b2, w_b3, w_b4;
  logic [63:0]  w_d0, w_d1, w_d2, w_d3, w_d4;

  always_comb begin
    w_c    = i_state;
    w_c[2] = i_state[2] ^ rc(i_round);
  end

  assign w_b0 = w_c[0] ^ w_c[4];
  assign w_b1 = w_c[1];
  assign w_b2 = w_c[2] ^ w_c[1];
  assign w_b3 = w_c[3];
  assign w_b4 = w_c[4] ^ w_c[3];

  // Chi-like nonlinear step across the five lanes.
  assign w_d0 = w_b0 ^ (~w_b1 & w_b2);
  assign w_d1 = w_b1 ^ (~w_b2 & w_b3);
  assign w_d2 = w_b2 ^ (~w_b3 & w_b4);
  assign w_d3 = w_b3 ^ (~w_b4 & w_b0);
  assign w_d4 = w_b4 ^ (~w_b0 & w_b1);

  assign w_s[0] = w_d0 ^ w_d4;
  assign w_s[1] = w_d1 ^ w_d0;
  assign w_s[2] = ~w_d2;
  assign w_s[3] = w_d3 ^ w_d2;
  assign w_s[4] = w_d4;

  for (genvar i = 0; i < 5; i++) begin : g_lin
    localparam int A = ROT_A[i];
    localparam int B = ROT_B[i];
    assign w_l[i] = w_s[i] ^ {w_s[i][A-1:0], w_s[i][63:A]} ^ {w_s[i][B-1:0], w_s[i][63:B]};
  end

  assign o_state = i_enable ? w_l : i_state;

endmodule

// File: rtl/ascon_perm_core.sv
// Sequential Ascon p^nr engine with word-wise state access and start/done handshake.
// Optional zeroize port enabled by defining ASCON_PERM_FLUSH_EN.
module ascon_perm_core
  import ascon_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int RPC  = 1
) (
  input  logic            g_clk,
  input  logic            g_resetn,
`ifdef ASCON_PERM_FLUSH_EN
  input  logic            flush,
`endif
  input  logic            wr_en,
  input  logic [3:0]      wr_idx,
  input  logic [XLEN-1:0] wr_data,
  input  logic [3:0]      rd_idx,
  output logic [XLEN-1:0] rd_data,
  input  logic            start_valid,
  input  logic [3:0]      start_nr,
  output logic            start_ready,
  output logic            busy,
  output logic            done
);

  localparam int         NW    = 320 / XLEN;
  localparam logic [3:0] NW_L  = 4'(NW);
  localparam logic [3:0] RMAX  = 4'(NROUNDS_MAX);
  localparam logic [3:0] RPC_L = 4'(RPC);

  perm_fsm_e       r_fsm, w_fsm_next;
  ascon_state_t    r_state, w_wr_state;
  logic [3:0]      r_round, w_round_next, w_nr;
  logic            r_done, w_done_next, w_accept, w_wr_ok;
  logic [XLEN-1:0] w_rd_word;
  ascon_state_t    w_chain [RPC+1];

  assign w_wr_ok = wr_en && (r_fsm == ST_IDLE) && (wr_idx < NW_L);

  // 32-bit builds split each lane into low word (even index) and high word (odd index).
  if (XLEN == 64) begin : g_io64
    always_comb begin
      w_wr_state = r_state;
      if (w_wr_ok) w_wr_state[wr_idx[2:0]] = wr_data;
    end
    assign w_rd_word = (rd_idx < NW_L) ? r_state[rd_idx[2:0]] : '0;
  end else begin : g_io32
    always_comb begin
      w_wr_state = r_state;
      if (w_wr_ok) begin
        if (wr_idx[0]) w_wr_state[wr_idx[3:1]][63:32] = wr_data;
        else           w_wr_state[wr_idx[3:1]][31:0]  = wr_data;
      end
    end
    assign w_rd_word = (rd_idx >= NW_L) ? '0 :
                       rd_idx[0] ? r_state[rd_idx[3:1]][63:32] : r_state[rd_idx[3:1]][31:0];
  end

  // Unrolled stages past round 11 fall through, covering odd nr with RPC=2.
  assign w_chain[0] = r_state;
  for (genvar j = 0; j < RPC; j++) begin : g_stage
    logic [3:0] w_ridx;
    assign w_ridx = r_round + 4'(j);
    ascon_round u_round (
      .i_state  (w_chain[j]),
      .i_round  (w_ridx),
      .i_enable (w_ridx < RMAX),
      .o_state  (w_chain[j+1])
    );
  end

  assign w_round_next = (r_round + RPC_L >= RMAX) ? RMAX : r_round + RPC_L;
  assign w_nr         = (start_nr > RMAX) ? RMAX : start_nr;

  always_comb begin
    w_fsm_next  = r_fsm;
    w_accept    = 1'b0;
    w_done_next = 1'b0;
    case (r_fsm)
      ST_IDLE: begin
        if (start_valid) begin
          w_accept = 1'b1;
          if (w_nr == 4'd0) w_done_next = 1'b1;
          else              w_fsm_next  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_round_next == RMAX) begin
          w_fsm_next  = ST_IDLE;
          w_done_next = 1'b1;
        end
      end
      default: w_fsm_next = ST_IDLE;
    endcase
  end

  // A write in the accepting cycle lands in r_state before the first round runs.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_fsm   <= ST_IDLE;
      r_state <= '0;
      r_round <= '0;
      r_done  <= 1'b0;
`ifdef ASCON_PERM_FLUSH_EN
    end else if (flush) begin
      r_fsm   <= ST_IDLE;
      r_state <= '0;
      r_round <= '0;
      r_done  <= 1'b0;
`endif
    end else begin
      r_fsm  <= w_fsm_next;
      r_done <= w_done_next;
      if (r_fsm == ST_RUN) begin
        r_state <= w_chain[RPC];
        r_round <= w_round_next;
      end else begin
        r_state <= w_wr_state;
        if (w_accept) r_round <= RMAX - w_nr;
      end
    end
  end

  assign start_ready = (r_fsm == ST_IDLE);
  assign busy        = (r_fsm == ST_RUN);
  assign done        = r_done;
  assign rd_data     = w_rd_word;

endmodule
